// File: rtl/snn_cfg_serial_writer_pkg.sv
// snn_cfg_serial_writer_pkg: shared widths, state encoding and register map for the config writer
package snn_cfg_pkg;

    localparam int CFG_ADDR_W   = 4;
    localparam int CFG_DATA_W   = 8;
    localparam int CFG_MAX_ADDR = 14;
    localparam int CFG_CNT_W    = 5;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} cfg_state_t;

    localparam logic [CFG_ADDR_W-1:0] A_THRESHOLD = 4'd0;
    localparam logic [CFG_ADDR_W-1:0] A_LEAK      = 4'd1;
    localparam logic [CFG_ADDR_W-1:0] A_REFRAC    = 4'd2;
    localparam logic [CFG_ADDR_W-1:0] A_W1_BASE   = 4'd3;
    localparam logic [CFG_ADDR_W-1:0] A_W2_BASE   = 4'd6;

    function automatic logic [CFG_CNT_W-1:0] sat_inc(input logic [CFG_CNT_W-1:0] a);
        return (&a) ? a : a + 1'b1;
    endfunction

endpackage

// File: rtl/snn_cfg_serial_writer_if.sv
// snn_cfg_serial_writer_if: serial host pins plus the register-file write port
interface snn_cfg_serial_writer_if;
    import snn_cfg_pkg::*;

    logic                  ser_cs_n;
    logic                  ser_sclk;
    logic                  ser_mosi;
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data_out;
    logic                  write_enable;
    logic                  frame_err;
    logic                  busy;

    modport master (
        input  ser_cs_n, ser_sclk, ser_mosi,
        output addr, data_out, write_enable, frame_err, busy
    );

    modport slave (
        output ser_cs_n, ser_sclk, ser_mosi,
        input  addr, data_out, write_enable, frame_err, busy
    );
endinterface

// File: rtl/snn_cfg_serial_writer_sync_ff.sv
// snn_sync_ff: multi-stage synchronizer with a per-bit reset value
module snn_sync_ff #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // shift the asynchronous inputs through DEPTH flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/snn_cfg_serial_writer.sv
// snn_cfg_serial_writer: bit-serial frame receiver driving the neuron register-file write port
module snn_cfg_serial_writer
    import snn_cfg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = CFG_MAX_ADDR
) (
    input logic                    clk,
    input logic                    reset,
    snn_cfg_serial_writer_if.master bus
);

    logic [2:0]             sync;
    logic                   mosi_s, sclk_s, cs_s;
    logic [SYNC_STAGES-1:0] flush_q;
    logic                   arm_q, sclk_prev_q, cs_prev_q;
    logic                   sclk_rise, cs_fall, cs_rise;

    cfg_state_t             state_q, state_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [CFG_DATA_W-1:0]  shift_q, shift_d;
    logic [CFG_CNT_W-1:0]   acnt_q, acnt_d;
    logic [CFG_ADDR_W-1:0]  addr_q, addr_d;
    logic [CFG_DATA_W-1:0]  data_q, data_d;
    logic                   we_q, we_d;
    logic                   err_q, err_d;
    logic [CFG_DATA_W-1:0]  byte_in;

    snn_sync_ff #(.WIDTH(3), .DEPTH(SYNC_STAGES), .RST_VAL(3'b011)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   ({bus.ser_mosi, bus.ser_sclk, bus.ser_cs_n}),
        .q_o   (sync)
    );

    assign {mosi_s, sclk_s, cs_s} = sync;

    // a cs_n falling edge only counts once cs_n has really been seen high after the
    // synchronizer has flushed its reset value, so a pin held low through reset starts nothing
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_fall   = arm_q & cs_prev_q & ~cs_s;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign byte_in   = {shift_q[CFG_DATA_W-2:0], mosi_s};

    // edge-detect history and frame-start arming
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_q     <= '0;
            arm_q       <= 1'b0;
            sclk_prev_q <= 1'b1;
            cs_prev_q   <= 1'b1;
        end else begin
            flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
            arm_q       <= arm_q | (&flush_q & cs_s);
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next state: cs_n rise always wins over a coincident sclk rise
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cs_fall ? ADDR : IDLE;
            ADDR:    state_d = cs_rise ? IDLE : (sclk_rise && bitcnt_q == 3'd3) ? DATA : ADDR;
            DATA:    state_d = cs_rise ? IDLE : DATA;
            default: state_d = IDLE;
        endcase
    end

    // datapath next values: bit shifting, address counting, write issue and error tracking
    always_comb begin
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        acnt_d   = acnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    bitcnt_d = '0;
                    err_d    = 1'b0;
                end
            end
            ADDR: begin
                if (cs_rise) begin
                    err_d = 1'b1;
                end else if (sclk_rise) begin
                    acnt_d   = {1'b0, acnt_q[CFG_ADDR_W-2:0], mosi_s};
                    bitcnt_d = (bitcnt_q == 3'd3) ? 3'd0 : bitcnt_q + 3'd1;
                end
            end
            DATA: begin
                if (cs_rise) begin
                    err_d = err_q | (bitcnt_q != 3'd0);
                end else if (sclk_rise) begin
                    shift_d  = byte_in;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        acnt_d = sat_inc(acnt_q);
                        if (acnt_q <= CFG_CNT_W'(MAX_ADDR)) begin
                            addr_d = acnt_q[CFG_ADDR_W-1:0];
                            data_d = byte_in;
                            we_d   = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitcnt_q <= '0;
            shift_q  <= '0;
            acnt_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            acnt_q   <= acnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            err_q    <= err_d;
        end
    end

    assign bus.addr         = addr_q;
    assign bus.data_out     = data_q;
    assign bus.write_enable = we_q;
    assign bus.frame_err    = err_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_snn_cfg_serial_writer.sv
// tb_snn_cfg_serial_writer: scenario tasks against a frame-level reference model
module tb_snn_cfg_serial_writer;
    import snn_cfg_pkg::*;

    localparam int PH = 4;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   we_run = 0;
    wr_t  got_q[$];
    wr_t  exp_q[$];
    logic [7:0] tx_q[$];
    logic [3:0] mdl_addr = '0;
    logic [7:0] mdl_data = '0;
    logic       mdl_err = 1'b0;

    always #5 clk = ~clk;

    snn_cfg_serial_writer_if bus ();

    snn_cfg_serial_writer #(.SYNC_STAGES(2), .MAX_ADDR(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // capture every strobe and check that each lasts exactly one clock
    always @(negedge clk) begin
        if (bus.write_enable === 1'b1) begin
            if (we_run == 0) got_q.push_back({bus.addr, bus.data_out});
            we_run++;
        end else begin
            if (we_run > 0) begin
                n_chk++;
                if (we_run !== 1) begin
                    n_fail++;
                    $display("FAIL strobe_width: got %0d cycles, expected 1", we_run);
                end
            end
            we_run = 0;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.ser_mosi = b;
        wait_clk(PH);
        bus.ser_sclk = 1'b1;
        wait_clk(PH);
        bus.ser_sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic start_frame(input logic [3:0] a);
        bus.ser_cs_n = 1'b0;
        wait_clk(PH);
        for (int i = 3; i >= 0; i--) send_bit(a[i]);
    endtask

    task automatic end_frame();
        wait_clk(PH);
        bus.ser_cs_n = 1'b1;
        wait_clk(4 * PH);
    endtask

    // frame-level model: byte i targets start+i (saturating at 31); targets above 14 are dropped
    task automatic build_model(input logic [3:0] a);
        int p = int'(a);
        exp_q.delete();
        mdl_err = 1'b0;
        foreach (tx_q[i]) begin
            if (p <= CFG_MAX_ADDR) begin
                exp_q.push_back({4'(p), tx_q[i]});
                mdl_addr = 4'(p);
                mdl_data = tx_q[i];
            end else begin
                mdl_err = 1'b1;
            end
            p = (p < 31) ? p + 1 : 31;
        end
    endtask

    task automatic check_outputs(input string name, input int n_wr, input logic err);
        n_chk++;
        if (got_q.size() !== n_wr) begin
            n_fail++;
            $display("FAIL %s_count: got %0d writes, expected %0d", name, got_q.size(), n_wr);
        end
        n_chk++;
        if (bus.frame_err !== err) begin
            n_fail++;
            $display("FAIL %s_err: got %b, expected %b", name, bus.frame_err, err);
        end
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy: got %b, expected 0", name, bus.busy);
        end
        n_chk++;
        if (bus.addr !== mdl_addr || bus.data_out !== mdl_data) begin
            n_fail++;
            $display("FAIL %s_hold: got addr %0d data %h, expected addr %0d data %h",
                     name, bus.addr, bus.data_out, mdl_addr, mdl_data);
        end
    endtask

    task automatic run_frame(input string name, input logic [3:0] a);
        build_model(a);
        got_q.delete();
        start_frame(a);
        n_chk++;
        if (bus.frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_err_clear: got %b, expected 0", name, bus.frame_err);
        end
        foreach (tx_q[i]) send_byte(tx_q[i]);
        end_frame();
        check_outputs(name, exp_q.size(), mdl_err);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_write%0d: got addr %0d data %h, expected addr %0d data %h",
                         name, i, got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_reset();
        bus.ser_cs_n = 1'b1;
        bus.ser_sclk = 1'b0;
        bus.ser_mosi = 1'b0;
        reset = 1'b1;
        wait_clk(3);
        n_chk++;
        if ({bus.addr, bus.data_out, bus.write_enable, bus.frame_err, bus.busy} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {bus.addr, bus.data_out, bus.write_enable, bus.frame_err, bus.busy});
        end
        reset = 1'b0;
        wait_clk(4 * PH);
        got_q.delete();
        check_outputs("post_reset", 0, 1'b0);
    endtask

    task automatic test_single();
        tx_q = '{8'h80};
        run_frame("single", 4'h0);
    endtask

    task automatic test_burst();
        tx_q = '{8'h11, 8'h22, 8'h33};
        run_frame("burst", 4'h3);
    endtask

    task automatic test_overflow();
        tx_q = '{8'hAA, 8'hBB, 8'hCC};
        run_frame("overflow", 4'hD);
    endtask

    task automatic test_abort();
        got_q.delete();
        start_frame(4'h1);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        end_frame();
        check_outputs("abort", 0, 1'b1);
        tx_q = '{8'h5A};
        run_frame("after_abort", 4'h1);
    endtask

    task automatic test_reset_mid();
        got_q.delete();
        start_frame(4'h2);
        send_bit(1'b1);
        send_bit(1'b0);
        wait_clk(1);
        reset = 1'b1;
        #1;
        n_chk++;
        if ({bus.addr, bus.data_out, bus.write_enable, bus.frame_err, bus.busy} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h, expected 0",
                     {bus.addr, bus.data_out, bus.write_enable, bus.frame_err, bus.busy});
        end
        mdl_addr = '0;
        mdl_data = '0;
        wait_clk(3);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)));
        wait_clk(PH);
        check_outputs("cs_low_after_reset", 0, 1'b0);
        bus.ser_cs_n = 1'b1;
        wait_clk(4 * PH);
        tx_q = '{8'hC3, 8'h3C};
        run_frame("after_reset", 4'h7);
    endtask

    task automatic test_collision();
        got_q.delete();
        start_frame(4'h4);
        for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
        bus.ser_mosi = 1'b1;
        wait_clk(PH);
        bus.ser_sclk = 1'b1;
        bus.ser_cs_n = 1'b1;
        wait_clk(PH);
        bus.ser_sclk = 1'b0;
        wait_clk(4 * PH);
        check_outputs("collision", 0, 1'b1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            tx_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 4)); i++) tx_q.push_back(8'($urandom));
            run_frame($sformatf("random%0d", f), 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
